// File: rtl/iob_pwm_sched_pkg.sv
// iob_pwm_sched_pkg: FSM encoding and timing constants shared by the PWM scheduler
package iob_pwm_sched_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
    localparam int MIN_PERIOD_EXTRA = 2;
    localparam int ROM_LAT = 1;
    function automatic int min_period(input int n_ch);
        return n_ch + MIN_PERIOD_EXTRA;
    endfunction
endpackage

// File: rtl/iob_pwm_sched_ch.sv
// iob_pwm_ch: per-channel shadow/active duty pair and registered PWM compare
module iob_pwm_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             cap,
    input  logic [CNT_W-1:0] cap_val,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);
    logic [CNT_W-1:0] shadow_q, shadow_d, duty_q, duty_d;
    logic             pwm_q, pwm_d;
    // shadow captures fetched duty, active duty swaps in at the boundary, output compares carrier
    always_comb begin
        shadow_d = cap ? cap_val : shadow_q;
        duty_d   = load ? shadow_q : (en ? duty_q : '0);
        pwm_d    = en && (cnt < duty_q);
    end
    // channel registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
        end
    end
    assign pwm = pwm_q;
endmodule

// File: rtl/iob_pwm_sched.sv
// iob_pwm_sched: time-shares one waveform ROM across N_CH PWM channels on a common carrier
module iob_pwm_sched
    import iob_pwm_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ROM_ADDR_W = 7,
    parameter int ROM_DATA_W = 16,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [CNT_W-1:0]           period,
    input  logic [N_CH*ROM_ADDR_W-1:0] step,
    output logic                       rom_en,
    output logic [ROM_ADDR_W-1:0]      rom_addr,
    input  logic [ROM_DATA_W-1:0]      rom_rdata,
    output logic [N_CH-1:0]            pwm_out,
    output logic                       busy
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(min_period(N_CH));

    state_e                        state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d, cap_idx;
    logic [CNT_W-1:0]              cnt_q, cnt_d, period_q, period_d, p_eff, cap_val;
    logic [ROM_ADDR_W-1:0]         phase_q [N_CH];
    logic [ROM_ADDR_W-1:0]         phase_d [N_CH];
    logic [ROM_DATA_W+CNT_W-1:0]   prod;
    logic                          boundary, cap_any;

    assign p_eff    = (period < P_MIN) ? P_MIN : period;
    assign boundary = en && (cnt_q == period_q - CNT_W'(1));

    // carrier counter, period latch and fetch sequencer
    always_comb begin
        cnt_d    = (!en || boundary) ? '0 : cnt_q + CNT_W'(1);
        period_d = (!en || boundary) ? p_eff : period_q;
        state_d  = state_q;
        ch_d     = ch_q;
        if (state_q == ST_ISSUE) begin
            ch_d = ch_q + CH_W'(1);
            if (ch_q == CH_W'(N_CH - 1))
                state_d = ST_DRAIN;
        end else if (state_q == ST_DRAIN) begin
            state_d = ST_IDLE;
        end
        if (boundary) begin
            state_d = ST_ISSUE;
            ch_d    = '0;
        end
        if (!en)
            state_d = ST_IDLE;
    end

    // advance the phase of the channel being issued this cycle
    always_comb begin
        for (int i = 0; i < N_CH; i++)
            phase_d[i] = (state_q == ST_ISSUE && ch_q == CH_W'(i))
                       ? phase_q[i] + step[i*ROM_ADDR_W +: ROM_ADDR_W] : phase_q[i];
    end

    // sequencer, carrier and phase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            period_q <= P_MIN;
            phase_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
        end
    end

    assign rom_en   = state_q == ST_ISSUE;
    assign rom_addr = rom_en ? phase_q[ch_q] : '0;
    assign busy     = state_q != ST_IDLE;

    // data returns one cycle after its read, so the capture trails the issue index
    assign cap_any = (state_q == ST_ISSUE && ch_q != '0) || state_q == ST_DRAIN;
    assign cap_idx = (state_q == ST_DRAIN) ? CH_W'(N_CH - ROM_LAT) : ch_q - CH_W'(ROM_LAT);
    assign prod    = {{CNT_W{1'b0}}, rom_rdata} * {{ROM_DATA_W{1'b0}}, period_q};
    assign cap_val = CNT_W'(prod >> ROM_DATA_W);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        iob_pwm_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .load    (boundary),
            .cap     (cap_any && cap_idx == CH_W'(i)),
            .cap_val (cap_val),
            .cnt     (cnt_q),
            .pwm     (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_iob_pwm_sched.sv
// tb_iob_pwm_sched: directed self-checking bench for the PWM scheduler
module tb_iob_pwm_sched;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] period;
    logic [27:0] step;
    logic        rom_en, busy;
    logic [6:0]  rom_addr;
    logic [15:0] rom_rdata = '0;
    logic [3:0]  pwm_out;
    int          checks = 0, errors = 0, rom_mode = 0, n;
    int          hi [4];
    int          stp [4] = '{1, 2, 4, 8};

    iob_pwm_sched dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .period    (period),
        .step      (step),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .pwm_out   (pwm_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sample(input logic [6:0] a);
        return rom_mode == 0 ? {a, 9'b0} : rom_mode == 1 ? 16'h8000 : (a != 7'd0 ? 16'hFFFF : 16'h0000);
    endfunction

    always @(posedge clk)
        if (rom_en)
            rom_rdata <= sample(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
        if (busy !== 1'b1)
            chk("busy_timeout", 32'(busy), 1);
    endtask

    task automatic measure(input int len);
        for (int c = 0; c < 4; c++)
            hi[c] = 0;
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < 4; c++)
                hi[c] += int'(pwm_out[c]);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; period = 16'd100; step = {7'd8, 7'd4, 7'd2, 7'd1}; rom_mode = 0;
        tick(); tick();
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            wait_busy(n);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("ramp_en_s%0d_c%0d", s, c), 32'(rom_en), 1);
                chk($sformatf("ramp_addr_s%0d_c%0d", s, c), 32'(rom_addr), 32'((stp[c] * s) % 128));
                tick();
            end
            chk($sformatf("drain_busy_s%0d", s), 32'(busy), 1);
            chk($sformatf("drain_rom_en_s%0d", s), 32'(rom_en), 0);
            tick();
            chk($sformatf("idle_busy_s%0d", s), 32'(busy), 0);
        end
        wait_busy(n);
        tick();
        measure(100);
        chk("ramp_duty_c0", 32'(hi[0]), 6);
        chk("ramp_duty_c1", 32'(hi[1]), 12);
        chk("ramp_duty_c2", 32'(hi[2]), 25);
        chk("ramp_duty_c3", 32'(hi[3]), 50);

        en = 1'b0; rom_mode = 1; period = 16'd100;
        tick();
        chk("en_off_pwm", 32'(pwm_out), 0);
        chk("en_off_busy", 32'(busy), 0);
        en = 1'b1;
        wait_busy(n);
        repeat (50) tick();
        period = 16'd200;
        wait_busy(n);
        chk("per_change_old", 32'(50 + n), 100);
        repeat (5) tick();
        wait_busy(n);
        chk("per_change_new", 32'(5 + n), 200);
        tick();
        measure(200);
        for (int c = 0; c < 4; c++)
            chk($sformatf("per200_duty_c%0d", c), 32'(hi[c]), 100);

        en = 1'b0; period = 16'd3;
        tick();
        en = 1'b1;
        wait_busy(n);
        for (int k = 0; k < 3; k++) begin
            repeat (5) tick();
            chk($sformatf("clamp_idle_%0d", k), 32'(busy), 0);
            wait_busy(n);
            chk($sformatf("clamp_period_%0d", k), 32'(5 + n), 6);
        end

        rst = 1'b1; en = 1'b0; period = 16'd100;
        tick();
        rst = 1'b0;
        tick();
        en = 1'b1;
        wait_busy(n);
        tick();
        chk("abort_ch1_addr", 32'(rom_addr), 0);
        en = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pwm", 32'(pwm_out), 0);
        chk("abort_rom_en", 32'(rom_en), 0);
        en = 1'b1;
        wait_busy(n);
        chk("abort_next_c0", 32'(rom_addr), 1); tick();
        chk("abort_next_c1", 32'(rom_addr), 2); tick();
        chk("abort_next_c2", 32'(rom_addr), 0); tick();
        chk("abort_next_c3", 32'(rom_addr), 0); tick();

        rst = 1'b1; en = 1'b0; step = {7'd1, 7'd0, 7'd1, 7'd0}; rom_mode = 2;
        tick();
        rst = 1'b0;
        tick();
        en = 1'b1;
        wait_busy(n);
        repeat (5) tick();
        wait_busy(n);
        repeat (5) tick();
        wait_busy(n);
        tick();
        measure(100);
        chk("ext_duty_c0", 32'(hi[0]), 0);
        chk("ext_duty_c1", 32'(hi[1]), 99);
        chk("ext_duty_c2", 32'(hi[2]), 0);
        chk("ext_duty_c3", 32'(hi[3]), 99);

        en = 1'b0; rom_mode = 1;
        tick();
        en = 1'b1;
        wait_busy(n);
        repeat (4) tick();
        chk("rst_drain_busy", 32'(busy), 1);
        chk("rst_drain_rom_en", 32'(rom_en), 0);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_rom_en", 32'(rom_en), 0);
        chk("rst_mid_rom_addr", 32'(rom_addr), 0);
        chk("rst_mid_pwm", 32'(pwm_out), 0);
        rst = 1'b0;
        wait_busy(n);
        tick();
        measure(100);
        for (int c = 0; c < 4; c++)
            chk($sformatf("rst_no_stale_c%0d", c), 32'(hi[c]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
